// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the fetch stage's memory, decode and redirect signals.
interface fetch_unit_if;

    logic        imem_o_req_valid;
    logic        imem_i_req_ready;
    logic [63:0] imem_o_req_addr;
    logic        imem_i_rsp_valid;
    logic [31:0] imem_i_rsp_data;
    logic        fetch_o_valid;
    logic [31:0] fetch_o_instr;
    logic [63:0] fetch_o_pc;
    logic        decode_i_ready;
    logic        execute_i_redirect;
    logic [63:0] execute_i_redirect_pc;

    modport master (
        output imem_o_req_valid, imem_o_req_addr,
        output fetch_o_valid, fetch_o_instr, fetch_o_pc,
        input  imem_i_req_ready, imem_i_rsp_valid, imem_i_rsp_data,
        input  decode_i_ready, execute_i_redirect, execute_i_redirect_pc
    );

    modport slave (
        input  imem_o_req_valid, imem_o_req_addr,
        input  fetch_o_valid, fetch_o_instr, fetch_o_pc,
        output imem_i_req_ready, imem_i_rsp_valid, imem_i_rsp_data,
        output decode_i_ready, execute_i_redirect, execute_i_redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch entries with flush; head reads as a NOP at pc 0 when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !flush && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = empty ? '{pc: 64'd0, instr: NOP_INSTR} : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_entry;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, request throttling, response tagging and redirect drop control.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int            CW  = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0]   CAP = (CW + 1)'(BUF_DEPTH);

    logic [63:0]   pc_reg, pc_next;
    logic [CW-1:0] inflight_reg, inflight_next;
    logic [CW-1:0] drop_reg, drop_next;
    logic [CW-1:0] buf_count, pcq_count;
    logic [CW:0]   occupancy;
    logic          redirect, req_fire, rsp_take, buf_push, buf_pop;
    logic          buf_full, buf_empty, pcq_full, pcq_empty;
    fetch_entry_t  buf_head, pcq_head, rsp_entry, req_entry;
    logic          unused_ok;

    assign redirect  = bus.execute_i_redirect;
    assign occupancy = {1'b0, buf_count} + {1'b0, inflight_reg};

    assign bus.imem_o_req_valid = rst && !redirect && (occupancy < CAP);
    assign bus.imem_o_req_addr  = pc_reg;

    assign req_fire = bus.imem_o_req_valid && bus.imem_i_req_ready;
    // Responses with nothing outstanding are protocol violations and are ignored.
    assign rsp_take = bus.imem_i_rsp_valid && (inflight_reg != '0);
    assign buf_push = rsp_take && (drop_reg == '0) && !redirect;
    assign buf_pop  = bus.fetch_o_valid && bus.decode_i_ready;

    assign req_entry = '{pc: pc_reg, instr: 32'd0};
    assign rsp_entry = '{pc: pcq_head.pc, instr: bus.imem_i_rsp_data};

    always_comb begin
        pc_next       = pc_reg;
        inflight_next = inflight_reg + CW'(req_fire) - CW'(rsp_take);
        drop_next     = drop_reg;
        if (redirect) begin
            pc_next   = word_align(bus.execute_i_redirect_pc);
            drop_next = inflight_reg - CW'(rsp_take);
        end else begin
            if (req_fire) pc_next = pc_reg + 64'd4;
            if (rsp_take && (drop_reg != '0)) drop_next = drop_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg       <= RESET_PC;
            inflight_reg <= '0;
            drop_reg     <= '0;
        end else begin
            pc_reg       <= pc_next;
            inflight_reg <= inflight_next;
            drop_reg     <= drop_next;
        end
    end

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (buf_push),
        .push_entry (rsp_entry),
        .pop        (buf_pop),
        .flush      (redirect),
        .full       (buf_full),
        .empty      (buf_empty),
        .head       (buf_head),
        .count      (buf_count)
    );

    // Side-queue of request PCs; it survives redirects so late responses still pop their tag.
    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_pcq (
        .clk        (clk),
        .rst        (rst),
        .push       (req_fire),
        .push_entry (req_entry),
        .pop        (rsp_take),
        .flush      (1'b0),
        .full       (pcq_full),
        .empty      (pcq_empty),
        .head       (pcq_head),
        .count      (pcq_count)
    );

    assign bus.fetch_o_valid = (buf_count != '0);
    assign bus.fetch_o_instr = buf_head.instr;
    assign bus.fetch_o_pc    = buf_head.pc;

    assign unused_ok = ^{buf_full, buf_empty, pcq_full, pcq_empty, pcq_count, pcq_head.instr};

    a_rsp_has_request: assert property (
        @(posedge clk) disable iff (!rst) bus.imem_i_rsp_valid |-> (inflight_reg != '0)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit with a queue-based reference model and memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          D   = 2;
    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state
    logic [63:0]  m_pc;
    int           m_inflight, m_drop;
    fetch_entry_t m_buf [$];
    logic [63:0]  m_tag [$];
    mreq_t        mem_q [$];

    // Expected outputs for the current cycle
    bit           cmp_en = 1'b0;
    logic         e_req_valid, e_valid;
    logic [63:0]  e_req_addr;
    fetch_entry_t e_head;

    // Stimulus knobs
    logic        k_run = 1'b0;
    int          k_ready_pct = 100, k_dec_pct = 100, k_redir_pct = 0;
    int          k_lat_min = 1, k_lat_max = 1, k_ready_force = -1;
    logic        k_redirect = 1'b0;
    logic [63:0] k_rpc = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'hA5C3_0F00;
    endfunction

    function automatic logic [63:0] pick_pc();
        case ($urandom_range(2))
            0:       return 64'h8000_0000 + 64'($urandom_range(4095));
            1:       return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    task automatic model_reset();
        m_pc       = RPC;
        m_inflight = 0;
        m_drop     = 0;
        m_buf.delete();
        m_tag.delete();
        mem_q.delete();
    endtask

    task automatic cycle();
        logic        rdy, dec, redir, rsp, fire;
        logic [63:0] rpc, tag;
        logic [31:0] data;
        mreq_t       mr;
        fetch_entry_t dummy;
        @(posedge clk);
        #1;
        cyc++;
        rdy   = (k_ready_force >= 0) ? (k_ready_force != 0) : ($urandom_range(99) < k_ready_pct);
        dec   = $urandom_range(99) < k_dec_pct;
        redir = k_redirect || ($urandom_range(99) < k_redir_pct);
        rpc   = k_redirect ? k_rpc : pick_pc();
        k_redirect = 1'b0;
        rsp = 1'b0;
        if (k_run && mem_q.size() > 0) rsp = (mem_q[0].due <= cyc);
        data = rsp ? instr_of(mem_q[0].addr) : 32'($urandom);

        e_req_valid = k_run && !redir && (m_buf.size() + m_inflight < D);
        e_req_addr  = m_pc;
        e_valid     = (m_buf.size() != 0);
        e_head      = e_valid ? m_buf[0] : '0;

        rst                       = k_run;
        bus.imem_i_req_ready      = rdy;
        bus.decode_i_ready        = dec;
        bus.execute_i_redirect    = redir;
        bus.execute_i_redirect_pc = rpc;
        bus.imem_i_rsp_valid      = rsp;
        bus.imem_i_rsp_data       = data;
        cmp_en = 1'b1;

        if (!k_run) begin
            model_reset();
        end else begin
            fire = e_req_valid && rdy;
            if (rsp) mr = mem_q.pop_front();
            if (redir) begin
                m_buf.delete();
                m_drop = m_inflight - (rsp ? 1 : 0);
                if (rsp) tag = m_tag.pop_front();
                m_pc = {rpc[63:2], 2'b00};
            end else begin
                if (e_valid && dec) dummy = m_buf.pop_front();
                if (rsp) begin
                    tag = m_tag.pop_front();
                    if (m_drop > 0) m_drop--;
                    else m_buf.push_back('{pc: tag, instr: data});
                end
                if (fire) begin
                    m_tag.push_back(m_pc);
                    mem_q.push_back('{addr: m_pc, due: cyc + int'($urandom_range(k_lat_max, k_lat_min))});
                    m_pc = m_pc + 64'd4;
                end
            end
            m_inflight = m_inflight + (fire ? 1 : 0) - (rsp ? 1 : 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_head(input string name, input logic [63:0] exp_pc);
        int i;
        i = 0;
        while (!bus.fetch_o_valid && i < 20) begin
            cycle();
            i++;
        end
        #2;
        chk({name, "_valid"}, bus.fetch_o_valid, 1);
        chk({name, "_pc"}, bus.fetch_o_pc, exp_pc);
    endtask

    // Every cycle the outputs are meaningful, compare against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_valid", bus.imem_o_req_valid, e_req_valid);
            if (e_req_valid) chk("req_addr", bus.imem_o_req_addr, e_req_addr);
            chk("fetch_valid", bus.fetch_o_valid, e_valid);
            if (e_valid) begin
                chk("fetch_pc", bus.fetch_o_pc, e_head.pc);
                chk("fetch_instr", bus.fetch_o_instr, 64'(e_head.instr));
            end
        end
    end

    initial begin
        bus.imem_i_req_ready      = 1'b0;
        bus.decode_i_ready        = 1'b0;
        bus.execute_i_redirect    = 1'b0;
        bus.execute_i_redirect_pc = 64'd0;
        bus.imem_i_rsp_valid      = 1'b0;
        bus.imem_i_rsp_data       = 32'd0;
        model_reset();

        // Reset state
        k_run = 1'b0;
        run(3);
        #2;
        chk("rst_req_valid", bus.imem_o_req_valid, 0);
        chk("rst_fetch_valid", bus.fetch_o_valid, 0);
        chk("rst_instr", bus.fetch_o_instr, 64'(NOP_INSTR));
        chk("rst_pc", bus.fetch_o_pc, 0);

        // Streaming with a 1-cycle memory and ready decode
        k_run = 1'b1;
        cycle(); #2;
        chk("a_req0_valid", bus.imem_o_req_valid, 1);
        chk("a_req0_addr", bus.imem_o_req_addr, 64'h8000_0000);
        cycle(); #2;
        chk("a_req1_addr", bus.imem_o_req_addr, 64'h8000_0004);
        cycle(); #2;
        chk("a_head0_pc", bus.fetch_o_pc, 64'h8000_0000);
        chk("a_head0_instr", bus.fetch_o_instr, 64'(instr_of(64'h8000_0000)));
        cycle(); #2;
        chk("a_head1_pc", bus.fetch_o_pc, 64'h8000_0004);
        chk("a_req2_addr", bus.imem_o_req_addr, 64'h8000_0008);
        run(20);

        // Decode stalled: buffer fills, requests stop, then drain in order
        k_run = 1'b0; cycle();
        k_run = 1'b1; k_dec_pct = 0;
        run(6); #2;
        chk("b_stall_req_valid", bus.imem_o_req_valid, 0);
        chk("b_stall_head_pc", bus.fetch_o_pc, 64'h8000_0000);
        k_dec_pct = 100;
        cycle(); #2;
        chk("b_drain_first_pc", bus.fetch_o_pc, 64'h8000_0000);
        cycle(); #2;
        chk("b_resume_req_valid", bus.imem_o_req_valid, 1);
        chk("b_resume_req_addr", bus.imem_o_req_addr, 64'h8000_0008);
        run(10);

        // Redirect with two requests in flight, 3-cycle memory
        k_run = 1'b0; cycle();
        k_run = 1'b1; k_lat_min = 3; k_lat_max = 3;
        cycle(); cycle();
        k_redirect = 1'b1; k_rpc = 64'h8000_0102;
        cycle(); #2;
        chk("c_redir_req_valid", bus.imem_o_req_valid, 0);
        cycle(); cycle(); #2;
        chk("c_new_req_addr", bus.imem_o_req_addr, 64'h8000_0100);
        wait_head("c_first", 64'h8000_0100);
        run(10);

        // Redirect coinciding with a response and a decode pop
        k_run = 1'b0; cycle();
        k_run = 1'b1; k_lat_min = 1; k_lat_max = 1;
        cycle(); cycle();
        k_redirect = 1'b1; k_rpc = 64'h8000_0200;
        cycle(); cycle(); #2;
        chk("d_empty_after", bus.fetch_o_valid, 0);
        chk("d_req_addr", bus.imem_o_req_addr, 64'h8000_0200);
        wait_head("d_first", 64'h8000_0200);
        run(10);

        // Request-ready pattern 1,0,0,1 with 3-cycle responses
        k_lat_min = 3; k_lat_max = 3; k_dec_pct = 70;
        for (int i = 0; i < 40; i++) begin
            k_ready_force = ((i % 4) == 0 || (i % 4) == 3) ? 1 : 0;
            cycle();
        end
        k_ready_force = -1;

        // Reset with a full buffer
        k_lat_min = 1; k_lat_max = 1; k_dec_pct = 0;
        run(8); #2;
        chk("f_full_valid", bus.fetch_o_valid, 1);
        k_run = 1'b0; cycle();
        k_run = 1'b1; cycle(); #2;
        chk("f_post_valid", bus.fetch_o_valid, 0);
        chk("f_post_instr", bus.fetch_o_instr, 64'(NOP_INSTR));
        chk("f_post_pc", bus.fetch_o_pc, 0);
        chk("f_post_req_addr", bus.imem_o_req_addr, 64'h8000_0000);

        // Randomised traffic, redirects and occasional resets
        for (int blk = 0; blk < 15; blk++) begin
            k_ready_pct = 30 + int'($urandom_range(70));
            k_dec_pct   = 20 + int'($urandom_range(80));
            k_redir_pct = int'($urandom_range(8));
            k_lat_min   = 1 + int'($urandom_range(1));
            k_lat_max   = k_lat_min + int'($urandom_range(3));
            for (int i = 0; i < 200; i++) begin
                k_run = ($urandom_range(199) != 0);
                cycle();
            end
        end
        k_run = 1'b1;
        cycle();

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
